uart_board_loader: RTL

Receives a seed board from a host over an 8N1 UART line and writes it cell-by-cell into the cell BRAM write port, so a 64×64 board can be loaded without resynthesis. Sits beside the Conway engine on the 108 MHz pixel clock. It is the writer counterpart to the draw and engine readers. Top level muxes its `addr/we/dout` onto a BRAM port and holds the engine and buffer swap while `busy` is high.

---
 rtl/uart_board_loader_if.sv | 13 +
 rtl/uart_board_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_board_loader_if.sv
// Cell-write bus from the UART board loader toward the cell BRAM port mux.
// The loader drives every signal through the master modport.
interface uart_board_loader_if;
    logic [11:0] addr;
    logic        we;
    logic        dout;
    logic        busy;
    logic        done;
    logic        err;

    modport master (output addr, we, dout, busy, done, err);
    modport slave  (input  addr, we, dout, busy, done, err);
endinterface

// File: rtl/uart_board_loader.sv
// Receives 'L' plus 512 bytes over 8N1 UART and writes them bit-by-bit into the 64x64 cell BRAM.
// Optional macro LOADER_CKSUM_EN: a trailing byte must equal the XOR of all data bytes.
module uart_board_loader #(
    parameter int CLKS_PER_BIT = 938,
    parameter int TIMEOUT_CLKS = 108000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    uart_board_loader_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
`ifdef LOADER_CKSUM_EN
        CKSUM,
`endif
        FINISH
    } state_t;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;
    logic          byte_ok;
    logic          frame_bad;

    state_t        state;
    logic [11:0]   addr_q;
    logic          we_q;
    logic          dout_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [8:0]    byte_cnt;
    logic [2:0]    bit_i;
    logic [2:0]    next_i;
    logic [7:0]    data;
    logic [TW-1:0] timer;
    logic          timed_out;
`ifdef LOADER_CKSUM_EN
    logic [7:0]    xor_acc;
`endif

    assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    // The loader reacts on the very edge that samples the stop bit.
    assign byte_ok   = (rx_state == RX_STOP) && bit_end && rx_sync;
    assign frame_bad = (rx_state == RX_STOP) && bit_end && !rx_sync;
    assign next_i    = bit_i + 3'd1;
    assign timed_out = (timer == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    // A line back high at mid start bit was only a glitch.
                    if (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        clk_cnt  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            byte_cnt <= '0;
            bit_i    <= '0;
            data     <= '0;
            timer    <= '0;
`ifdef LOADER_CKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_ok && shift == 8'h4C) begin
                        state    <= LOAD;
                        busy_q   <= 1'b1;
                        byte_cnt <= '0;
                        timer    <= '0;
`ifdef LOADER_CKSUM_EN
                        xor_acc  <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (byte_ok) begin
                        state  <= WRITE;
                        data   <= shift;
                        timer  <= '0;
                        we_q   <= 1'b1;
                        addr_q <= {byte_cnt, 3'd0};
                        dout_q <= shift[0];
                        bit_i  <= '0;
`ifdef LOADER_CKSUM_EN
                        xor_acc <= xor_acc ^ shift;
`endif
                    end else if (frame_bad || timed_out) begin
                        state  <= IDLE;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WRITE: begin
                    // The timer keeps running so a timeout is measured from the stop sample.
                    timer <= timer + 1'b1;
                    if (bit_i == 3'd7) begin
                        we_q <= 1'b0;
                        if (byte_cnt == 9'd511) begin
`ifdef LOADER_CKSUM_EN
                            state <= CKSUM;
`else
                            state <= FINISH;
`endif
                        end else begin
                            state    <= LOAD;
                            byte_cnt <= byte_cnt + 9'd1;
                        end
                    end else begin
                        bit_i  <= next_i;
                        addr_q <= {byte_cnt, next_i};
                        dout_q <= data[next_i];
                    end
                end
`ifdef LOADER_CKSUM_EN
                CKSUM: begin
                    if (byte_ok && shift == xor_acc) begin
                        state <= FINISH;
                    end else if (byte_ok || frame_bad || timed_out) begin
                        state  <= IDLE;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                FINISH: begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr = addr_q;
    assign bus.we   = we_q;
    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule
